mantissa_aligner: RTL and testbench

Sequential alignment stage directly downstream of the operand swap/selection stage in the FP add/sub datapath. Accepts the already-swapped operand pair: the smaller-exponent mantissa to be shifted and the larger-exponent mantissa passed through. It right-shifts the smaller mantissa by the exponent difference, STEP bits per cycle, and accumulates a sticky bit. The aligned pair and the common exponent go to the mantissa adder over a valid/ready handshake.

---
 rtl/mantissa_aligner_pkg.sv | 13 +
 rtl/mantissa_aligner_if.sv | 11 +
 rtl/mantissa_aligner_step.sv | 14 +
 rtl/mantissa_aligner.sv | 73 +++++++
 tb/tb_mantissa_aligner.sv | 92 +++++++++
 5 files changed

// File: rtl/mantissa_aligner_pkg.sv
// mantissa_aligner_pkg: shared FP alignment widths, state encoding and shift clamp
package mantissa_aligner_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 26;
    localparam int STEP   = 4;
    localparam int CNT_W  = $clog2(MANT_W + 1);
    localparam int SW     = $clog2(STEP + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    // Negative difference shifts nothing; anything past MANT_W already flushes the mantissa
    function automatic logic [CNT_W-1:0] shift_amt(input logic [EXP_W:0] d);
        return d[EXP_W] ? '0 : (d >= (EXP_W+1)'(MANT_W)) ? CNT_W'(MANT_W) : d[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/mantissa_aligner_if.sv
// mantissa_aligner_if: operand input and aligned-result output handshakes
interface mantissa_aligner_if;
    import mantissa_aligner_pkg::*;
    logic              in_valid, in_ready, out_valid, out_ready, sticky, err;
    logic [EXP_W-1:0]  exp_shift, exp_out, exp_res;
    logic [MANT_W-1:0] mantis_shift, mantis_out, mantis_aligned, mantis_big;
    modport master(output in_valid, exp_shift, exp_out, mantis_shift, mantis_out, out_ready,
                   input in_ready, out_valid, mantis_aligned, mantis_big, exp_res, sticky, err);
    modport slave(input in_valid, exp_shift, exp_out, mantis_shift, mantis_out, out_ready,
                  output in_ready, out_valid, mantis_aligned, mantis_big, exp_res, sticky, err);
endinterface

// File: rtl/mantissa_aligner_step.sv
// align_step: one combinational right shift of up to STEP bits, reporting dropped bits
module align_step
    import mantissa_aligner_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [SW-1:0]     s_i,
    output logic [MANT_W-1:0] mant_o,
    output logic              drop_o
);
    logic [MANT_W-1:0] mask;
    assign mask   = ~({MANT_W{1'b1}} << s_i);
    assign mant_o = mant_i >> s_i;
    assign drop_o = |(mant_i & mask);
endmodule

// File: rtl/mantissa_aligner.sv
// mantissa_aligner: multi-cycle right shift of the smaller mantissa with sticky accumulation
module mantissa_aligner
    import mantissa_aligner_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mantissa_aligner_if.slave  io
);
    state_e            state_q, state_d;
    logic [MANT_W-1:0] shift_q, shift_d, big_q, big_d, step_mant;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              sticky_q, sticky_d, err_q, err_d, step_drop;
    logic [EXP_W:0]    diff;
    logic [SW-1:0]     s;
    assign diff = {1'b0, io.exp_out} - {1'b0, io.exp_shift};
    assign s    = (rem_q < CNT_W'(STEP)) ? rem_q[SW-1:0] : SW'(STEP);
    align_step u_step (.mant_i(shift_q), .s_i(s), .mant_o(step_mant), .drop_o(step_drop));
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        big_d    = big_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                shift_d  = io.mantis_shift;
                big_d    = io.mantis_out;
                exp_d    = io.exp_out;
                rem_d    = shift_amt(diff);
                err_d    = diff[EXP_W];
                sticky_d = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: if (rem_q == '0) state_d = DONE;
                   else begin
                       shift_d  = step_mant;
                       sticky_d = sticky_q | step_drop;
                       rem_d    = rem_q - CNT_W'(s);
                   end
            DONE: state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            big_q    <= '0;
            exp_q    <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            big_q    <= big_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end
    assign io.in_ready       = state_q == IDLE;
    assign io.out_valid      = state_q == DONE;
    assign io.mantis_aligned = {shift_q[MANT_W-1:1], shift_q[0] | sticky_q};
    assign io.mantis_big     = big_q;
    assign io.exp_res        = exp_q;
    assign io.sticky         = sticky_q;
    assign io.err            = err_q;
endmodule

// File: tb/tb_mantissa_aligner.sv
// tb_mantissa_aligner: directed vectors with hand-computed aligned mantissas, sticky and latency
module tb_mantissa_aligner;
    logic clk = 1'b0, rst = 1'b1;
    int total = 0, bad = 0;
    mantissa_aligner_if io();
    mantissa_aligner dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic [7:0] es, input logic [7:0] eo, input logic [25:0] ms,
                      input logic [25:0] mo, input int lat, input logic [25:0] al,
                      input logic st, input logic er);
        int n = 0;
        @(negedge clk);
        chk("in_ready_pre", 32'(io.in_ready), 1);
        io.exp_shift = es; io.exp_out = eo; io.mantis_shift = ms; io.mantis_out = mo;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.exp_shift = 8'h5A; io.exp_out = 8'hA5; io.mantis_shift = '1; io.mantis_out = '1;
        while (!io.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("aligned", 32'(io.mantis_aligned), 32'(al));
        chk("sticky", 32'(io.sticky), 32'(st));
        chk("err", 32'(io.err), 32'(er));
        chk("big", 32'(io.mantis_big), 32'(mo));
        chk("exp_res", 32'(io.exp_res), 32'(eo));
        chk("in_ready_done", 32'(io.in_ready), 0);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        chk("valid_drop", 32'(io.out_valid), 0);
        chk("ready_back", 32'(io.in_ready), 1);
    endtask

    initial begin
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        io.exp_shift = '0; io.exp_out = '0; io.mantis_shift = '0; io.mantis_out = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(io.out_valid), 0);
        chk("rst_ready", 32'(io.in_ready), 1);
        chk("rst_aligned", 32'(io.mantis_aligned), 0);
        chk("rst_flags", 32'({io.sticky, io.err}), 0);
        @(negedge clk); rst = 1'b0;
        op(8'h80, 8'h80, 26'h2000000, 26'h2ABCDEF, 1, 26'h2000000, 0, 0); drain();
        op(8'h80, 8'h85, 26'h3FFFFFF, 26'h3000001, 3, 26'h01FFFFF, 1, 0); drain();
        op(8'h80, 8'hA8, 26'h0000001, 26'h2000000, 8, 26'h0000001, 1, 0); drain();
        op(8'h80, 8'hA8, 26'h0000000, 26'h2000000, 8, 26'h0000000, 0, 0); drain();
        op(8'h80, 8'h84, 26'h0000010, 26'h2222222, 2, 26'h0000001, 0, 0); drain();
        op(8'h90, 8'h80, 26'h1555555, 26'h3333333, 1, 26'h1555555, 0, 1); drain();
        io.out_ready = 1'b0;
        op(8'h10, 8'h18, 26'h00000FF, 26'h2468ACE, 3, 26'h0000001, 1, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(io.out_valid), 1);
            chk("bp_aligned", 32'(io.mantis_aligned), 32'h0000001);
            chk("bp_ready", 32'(io.in_ready), 0);
        end
        @(negedge clk); io.out_ready = 1'b1;
        drain();
        op(8'h80, 8'h80, 26'h1234567, 26'h0FEDCBA, 1, 26'h1234567, 0, 0); drain();
        @(negedge clk);
        io.exp_shift = 8'h80; io.exp_out = 8'h8C; io.mantis_shift = 26'h3FFFFFF;
        io.mantis_out = 26'h1111111; io.in_valid = 1'b1;
        @(posedge clk); #1; io.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(io.out_valid), 0);
        chk("mid_rst_ready", 32'(io.in_ready), 1);
        chk("mid_rst_aligned", 32'(io.mantis_aligned), 0);
        chk("mid_rst_big", 32'(io.mantis_big), 0);
        chk("mid_rst_exp", 32'(io.exp_res), 0);
        chk("mid_rst_flags", 32'({io.sticky, io.err}), 0);
        @(negedge clk); rst = 1'b0;
        op(8'h80, 8'h8C, 26'h2345678, 26'h1111111, 4, 26'h0002345, 1, 0); drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
